// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// MIPS opcode constants and instruction field positions.
package pipe_hazard_ctrl_pkg;

  // 2'b11 is never entered; the controller treats it like ST_RUN.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MEMWAIT = 2'b01,
    ST_ERR     = 2'b10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  // rt is read as a source operand only by R-type and sw; lw writes rt.
  function automatic logic rt_is_source(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-side signals exchanged with the hazard controller.
// master: the pipeline datapath; slave: the controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_instr;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             idex_hold;
  logic             exmem_hold;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       state_o;

  modport master (
    output id_instr, ex_memread, ex_rt, branch_taken, dmem_req, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold,
           exmem_hold, mem_timeout_err, stall_count, state_o
  );

  modport slave (
    input  id_instr, ex_memread, ex_rt, branch_taken, dmem_req, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold,
           exmem_hold, mem_timeout_err, stall_count, state_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection: compares the ID-stage source registers against
// the destination of a load currently in EX.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [31:0] id_instr,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  output logic        load_use
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       unused_low;

  assign op = id_instr[OP_MSB:OP_LSB];
  assign rs = id_instr[RS_MSB:RS_LSB];
  assign rt = id_instr[RT_MSB:RT_LSB];
  // The low half (rd/shamt/funct/immediate) never names a source register.
  assign unused_low = ^id_instr[15:0];

  // $zero never carries a real dependency, so a load to r0 is ignored.
  always_comb begin
    load_use = ex_memread && (ex_rt != 5'd0) &&
               ((rs == ex_rt) || (rt_is_source(op) && (rt == ex_rt)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and data-memory
// wait handling with a timeout that latches into a sticky error state.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic load_use;
  logic mem_stall;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold;

  hazard_detect u_hazard_detect (
    .id_instr   (bus.id_instr),
    .ex_memread (bus.ex_memread),
    .ex_rt      (bus.ex_rt),
    .load_use   (load_use)
  );

  assign mem_stall = bus.dmem_req && !bus.dmem_ready;

  // Next-state, wait timer and per-cycle pipeline controls.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    err_d       = err_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;

    case (state_q)
      ST_ERR: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_hold  = 1'b1;
        exmem_hold = 1'b1;
      end
      default: begin
        if (mem_stall) begin
          // Freeze everything up to MEM; branch and load-use wait their turn.
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
          exmem_hold = 1'b1;
          if (state_q == ST_MEMWAIT) begin
            timer_d = timer_q + TMR_W'(1);
            if (timer_d == TMR_W'(MEM_TIMEOUT)) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end else begin
              state_d = ST_MEMWAIT;
            end
          end else begin
            timer_d = '0;
            state_d = ST_MEMWAIT;
          end
        end else begin
          state_d = ST_RUN;
          timer_d = '0;
          if (bus.branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
      end
    endcase

    stall_count_d = stall_count_q;
    if (!pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end

    // While in reset the pipeline front end is frozen and fed NOPs.
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      idex_hold   = 1'b0;
      exmem_hold  = 1'b0;
    end
  end

  // State, timer, sticky error and stall counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      timer_q       <= '0;
      err_q         <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      err_q         <= err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.pc_write        = pc_write;
  assign bus.ifid_write      = ifid_write;
  assign bus.ifid_flush      = ifid_flush;
  assign bus.idex_bubble     = idex_bubble;
  assign bus.idex_hold       = idex_hold;
  assign bus.exmem_hold      = exmem_hold;
  assign bus.mem_timeout_err = err_q;
  assign bus.stall_count     = stall_count_q;
  assign bus.state_o         = state_q;

endmodule
